// File: rtl/axi_pkg.sv
// Shared AXI4 read-side definitions for the refill readers and the read arbiter.
package axi_pkg;

    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_LEN_W   = 4;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } refill_state_t;

endpackage

// File: rtl/axi_refill_reader_if.sv
// AXI4 read address/data channel bundle between a refill reader and the arbiter.
interface axi_refill_reader_if;
    import axi_pkg::*;

    logic [AXI_ADDR_W-1:0]  araddr;
    logic [AXI_LEN_W-1:0]   arlen;
    logic [AXI_SIZE_W-1:0]  arsize;
    logic [AXI_BURST_W-1:0] arburst;
    logic                   arvalid;
    logic                   arready;
    logic [AXI_DATA_W-1:0]  rdata;
    logic [AXI_RESP_W-1:0]  rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_refill_reader.sv
// Cache-miss refill: one AXI read burst per miss, beats assembled into a line.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a miss request
// ADDR    | AR channel valid, fields frozen until arready
// DATA    | accepting R beats into the line buffer, rready high
// DONE    | one-cycle done/err pulse, then back to IDLE
module axi_refill_reader
    import axi_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic [31:0]              req_addr,
    input  logic                     req_uncached,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [32*LINE_WORDS-1:0] line_data,
    axi_refill_reader_if.master      m_axi
);

    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [31:0] LINE_MASK = ~((32'(LINE_WORDS) << 2) - 32'd1);

    refill_state_t          r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic                   r_err_flag;
    logic                   r_arvalid;
    logic [AXI_ADDR_W-1:0]  r_araddr;
    logic [AXI_LEN_W-1:0]   r_arlen;
    logic [AXI_SIZE_W-1:0]  r_arsize;
    logic [AXI_BURST_W-1:0] r_arburst;
    logic                   r_uncached;
    logic [IDX_W-1:0]       r_word_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [31:0]            r_line [LINE_WORDS];

    logic                   w_beat;
    logic                   w_cnt_full;
    logic                   w_beat_bad;
    logic [IDX_W-1:0]       w_wr_idx;

    // rready is the only combinational output: it follows the state register
    assign m_axi.rready = (r_state == ST_DATA);
    assign w_beat       = (r_state == ST_DATA) && m_axi.rvalid;
    assign w_cnt_full   = (r_cnt == CNT_W'(LINE_WORDS));
    // A beat is bad on a non-OKAY response, when it runs past arlen, or when
    // rlast arrives with a beat count other than arlen+1.
    assign w_beat_bad   = (m_axi.rresp != AXI_RESP_OKAY)
                        || (32'(r_cnt) > 32'(r_arlen))
                        || (m_axi.rlast && (32'(r_cnt) != 32'(r_arlen)));
    // Uncached data lands in its natural slot so the cache can index it directly
    assign w_wr_idx     = r_uncached ? r_word_idx : r_cnt[IDX_W-1:0];

    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.araddr  = r_araddr;
    assign m_axi.arlen   = r_arlen;
    assign m_axi.arsize  = r_arsize;
    assign m_axi.arburst = r_arburst;

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
        assign line_data[32*g +: 32] = r_line[g];
    end

    // Request sequencing, AR channel registers, beat counting and error tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_flag <= 1'b0;
            r_arvalid  <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_arburst  <= '0;
            r_uncached <= 1'b0;
            r_word_idx <= '0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_state    <= ST_ADDR;
                        r_busy     <= 1'b1;
                        r_arvalid  <= 1'b1;
                        r_araddr   <= req_uncached ? {req_addr[31:2], 2'b00}
                                                   : (req_addr & LINE_MASK);
                        r_arlen    <= req_uncached ? '0 : AXI_LEN_W'(LINE_WORDS - 1);
                        r_arsize   <= AXI_SIZE_4B;
                        r_arburst  <= AXI_BURST_INCR;
                        r_uncached <= req_uncached;
                        r_word_idx <= IDX_W'((req_addr >> 2) & 32'(LINE_WORDS - 1));
                        r_err_flag <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_DATA;
                        r_cnt     <= '0;
                    end
                end
                ST_DATA: begin
                    if (m_axi.rvalid) begin
                        if (!w_cnt_full) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (w_beat_bad) begin
                            r_err_flag <= 1'b1;
                        end
                        if (m_axi.rlast) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= r_err_flag | w_beat_bad;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer: accepted beats are stored until the counter saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line[i] <= '0;
            end
        end else if (w_beat && !w_cnt_full) begin
            r_line[w_wr_idx] <= m_axi.rdata;
        end
    end

endmodule

// File: tb/tb_axi_refill_reader.sv
// Directed bench for axi_refill_reader with LINE_WORDS = 8.
module tb_axi_refill_reader;

    logic         clk;
    logic         rst_n;
    logic         req;
    logic [31:0]  req_addr;
    logic         req_uncached;
    logic         busy;
    logic         done;
    logic         err;
    logic [255:0] line_data;

    int checks;
    int errors;
    int cyc;

    logic [31:0] obs_araddr;
    logic [3:0]  obs_arlen;
    logic [2:0]  obs_arsize;
    logic [1:0]  obs_arburst;
    logic        obs_err;
    int          obs_done_cycle;
    int          obs_ar_cycles;
    bit          obs_timeout;
    bit          obs_ar_unstable;
    bit          obs_busy_low;

    axi_refill_reader_if s ();

    axi_refill_reader #(.LINE_WORDS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_addr     (req_addr),
        .req_uncached (req_uncached),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .line_data    (line_data),
        .m_axi        (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Runs one transaction as requester and slave; records what was observed.
    task automatic drive_txn(input logic [31:0] addr, input logic unc, input int ar_delay,
                             input bit gap, input int nbeats, input int bad_beat,
                             input logic [31:0] base);
        int  t0;
        int  ar_cnt;
        int  beat;
        bit  gap_pending;
        bit  got_ar;
        obs_timeout     = 1'b1;
        obs_ar_unstable = 1'b0;
        obs_busy_low    = 1'b0;
        obs_err         = 1'bx;
        obs_done_cycle  = -1;
        ar_cnt          = 0;
        beat            = 0;
        gap_pending     = gap;
        got_ar          = 1'b0;
        @(negedge clk);
        req          = 1'b1;
        req_addr     = addr;
        req_uncached = unc;
        t0           = cyc;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (!busy) obs_busy_low = 1'b1;
            if (done) begin
                obs_done_cycle = cyc - t0;
                obs_err        = err;
                obs_timeout    = 1'b0;
                s.rvalid       = 1'b0;
                s.rlast        = 1'b0;
                s.arready      = 1'b0;
                break;
            end
            if (s.rready) begin
                s.arready = 1'b0;
                if (gap_pending) begin
                    s.rvalid    = 1'b0;
                    gap_pending = 1'b0;
                end else begin
                    s.rvalid    = 1'b1;
                    s.rdata     = base + 32'(beat);
                    s.rresp     = (beat == bad_beat) ? 2'b10 : 2'b00;
                    s.rlast     = (beat == nbeats - 1);
                    beat++;
                    gap_pending = gap;
                end
            end else if (s.arvalid) begin
                if (!got_ar) begin
                    obs_araddr  = s.araddr;
                    obs_arlen   = s.arlen;
                    obs_arsize  = s.arsize;
                    obs_arburst = s.arburst;
                    got_ar      = 1'b1;
                end else if (s.araddr !== obs_araddr || s.arlen !== obs_arlen ||
                             s.arsize !== obs_arsize || s.arburst !== obs_arburst) begin
                    obs_ar_unstable = 1'b1;
                end
                s.arready = (ar_cnt >= ar_delay);
                ar_cnt++;
                // junk beat offered while the address is still pending
                s.rvalid = 1'b1;
                s.rdata  = 32'hBAD0_0BAD;
                s.rresp  = 2'b00;
                s.rlast  = 1'b1;
            end else begin
                s.arready = 1'b0;
                s.rvalid  = 1'b0;
                s.rlast   = 1'b0;
            end
        end
        obs_ar_cycles = ar_cnt;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        req          = 1'b0;
        req_addr     = '0;
        req_uncached = 1'b0;
        s.arready    = 1'b0;
        s.rvalid     = 1'b0;
        s.rdata      = '0;
        s.rresp      = '0;
        s.rlast      = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, s.arvalid, s.rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, s.arvalid, s.rready});
        end
        checks++;
        if ({s.araddr, s.arlen, s.arsize, s.arburst} !== 41'h0) begin
            errors++;
            $display("FAIL reset_ar: got %h expected 0", {s.araddr, s.arlen, s.arsize, s.arburst});
        end
        checks++;
        if (line_data !== 256'h0) begin
            errors++;
            $display("FAIL reset_line: got %h expected 0", line_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_cached_line;
        logic [255:0] exp_line;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hA0 + 32'(i);
        drive_txn(32'h1000_0024, 1'b0, 0, 1'b0, 8, -1, 32'hA0);
        checks++;
        if (obs_timeout) begin
            errors++;
            $display("FAIL cached_timeout: got no done expected done");
        end
        checks++;
        if (obs_araddr !== 32'h1000_0020) begin
            errors++;
            $display("FAIL cached_araddr: got %h expected 10000020", obs_araddr);
        end
        checks++;
        if ({obs_arlen, obs_arsize, obs_arburst} !== {4'd7, 3'b010, 2'b01}) begin
            errors++;
            $display("FAIL cached_arlen_size_burst: got %h/%b/%b expected 7/010/01", obs_arlen, obs_arsize, obs_arburst);
        end
        checks++;
        if (obs_done_cycle !== 10) begin
            errors++;
            $display("FAIL cached_done_cycle: got %0d expected 10", obs_done_cycle);
        end
        checks++;
        if (obs_err !== 1'b0) begin
            errors++;
            $display("FAIL cached_err: got %b expected 0", obs_err);
        end
        checks++;
        if (line_data !== exp_line) begin
            errors++;
            $display("FAIL cached_line: got %h expected %h", line_data, exp_line);
        end
        checks++;
        if (obs_busy_low !== 1'b0) begin
            errors++;
            $display("FAIL cached_busy: got busy low during transaction expected high");
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL cached_done_pulse: got done,busy=%b expected 00", {done, busy});
        end
    endtask

    task automatic test_stall;
        logic [255:0] exp_line;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h60 + 32'(i);
        drive_txn(32'h2000_0040, 1'b0, 5, 1'b1, 8, -1, 32'h60);
        checks++;
        if (obs_timeout) begin
            errors++;
            $display("FAIL stall_timeout: got no done expected done");
        end
        checks++;
        if (obs_ar_unstable !== 1'b0 || obs_ar_cycles !== 6) begin
            errors++;
            $display("FAIL stall_ar: got unstable=%b cycles=%0d expected 0 and 6", obs_ar_unstable, obs_ar_cycles);
        end
        checks++;
        if (obs_araddr !== 32'h2000_0040) begin
            errors++;
            $display("FAIL stall_araddr: got %h expected 20000040", obs_araddr);
        end
        checks++;
        if (obs_done_cycle !== 23) begin
            errors++;
            $display("FAIL stall_done_cycle: got %0d expected 23", obs_done_cycle);
        end
        checks++;
        if (line_data !== exp_line || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL stall_line: got %h err=%b expected %h err=0", line_data, obs_err, exp_line);
        end
    endtask

    task automatic test_resp_error;
        logic [255:0] exp_line;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hB0 + 32'(i);
        drive_txn(32'h3000_0000, 1'b0, 0, 1'b0, 8, 3, 32'hB0);
        checks++;
        if (obs_err !== 1'b1 || obs_done_cycle !== 10) begin
            errors++;
            $display("FAIL resp_err: got err=%b done@%0d expected err=1 done@10", obs_err, obs_done_cycle);
        end
        checks++;
        if (line_data !== exp_line) begin
            errors++;
            $display("FAIL resp_line: got %h expected %h", line_data, exp_line);
        end
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hC0 + 32'(i);
        drive_txn(32'h3000_0100, 1'b0, 0, 1'b0, 8, -1, 32'hC0);
        checks++;
        if (obs_err !== 1'b0 || obs_done_cycle !== 10) begin
            errors++;
            $display("FAIL resp_recover: got err=%b done@%0d expected err=0 done@10", obs_err, obs_done_cycle);
        end
        checks++;
        if (line_data !== exp_line) begin
            errors++;
            $display("FAIL resp_recover_line: got %h expected %h", line_data, exp_line);
        end
    endtask

    task automatic test_early_rlast;
        logic [255:0] exp_line;
        for (int i = 0; i < 6; i++) exp_line[32*i +: 32] = 32'hD0 + 32'(i);
        exp_line[32*6 +: 32] = 32'hC6;
        exp_line[32*7 +: 32] = 32'hC7;
        drive_txn(32'h3000_0200, 1'b0, 0, 1'b0, 6, -1, 32'hD0);
        checks++;
        if (obs_err !== 1'b1 || obs_done_cycle !== 8) begin
            errors++;
            $display("FAIL early_rlast: got err=%b done@%0d expected err=1 done@8", obs_err, obs_done_cycle);
        end
        checks++;
        if (line_data !== exp_line) begin
            errors++;
            $display("FAIL early_line: got %h expected %h", line_data, exp_line);
        end
    endtask

    task automatic test_extra_beat;
        logic [255:0] exp_line;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hE0 + 32'(i);
        drive_txn(32'h3000_0300, 1'b0, 0, 1'b0, 10, -1, 32'hE0);
        checks++;
        if (obs_err !== 1'b1 || obs_done_cycle !== 12) begin
            errors++;
            $display("FAIL extra_beat: got err=%b done@%0d expected err=1 done@12", obs_err, obs_done_cycle);
        end
        checks++;
        if (line_data !== exp_line) begin
            errors++;
            $display("FAIL extra_line: got %h expected %h", line_data, exp_line);
        end
    endtask

    task automatic test_uncached;
        logic [255:0] exp_line;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'hE0 + 32'(i);
        exp_line[32*2 +: 32] = 32'hDEAD_BEEF;
        drive_txn(32'h1FC0_0008, 1'b1, 0, 1'b0, 1, -1, 32'hDEAD_BEEF);
        checks++;
        if (obs_araddr !== 32'h1FC0_0008 || obs_arlen !== 4'd0) begin
            errors++;
            $display("FAIL uncached_ar: got %h len %0d expected 1fc00008 len 0", obs_araddr, obs_arlen);
        end
        checks++;
        if (obs_done_cycle !== 3 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL uncached_done: got done@%0d err=%b expected done@3 err=0", obs_done_cycle, obs_err);
        end
        checks++;
        if (line_data !== exp_line) begin
            errors++;
            $display("FAIL uncached_line: got %h expected %h", line_data, exp_line);
        end
    endtask

    task automatic test_reset_mid_burst;
        int  c_before;
        bit  seen;
        logic [255:0] exp_line;
        seen      = 1'b0;
        s.arready = 1'b1;
        @(negedge clk);
        req          = 1'b1;
        req_addr     = 32'h4000_0000;
        req_uncached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (s.rready) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_reset_reach_data: got no rready expected rready");
        end
        for (int b = 0; b < 3; b++) begin
            if (b > 0) @(negedge clk);
            s.rvalid = 1'b1;
            s.rdata  = 32'h90 + 32'(b);
            s.rresp  = 2'b00;
            s.rlast  = 1'b0;
        end
        checks++;
        if ({busy, s.rready} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_pre: got busy,rready=%b expected 11", {busy, s.rready});
        end
        c_before = cyc;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s.arvalid, s.rready, busy, done} !== 4'b0 || cyc !== c_before) begin
            errors++;
            $display("FAIL mid_reset_async: got arvalid,rready,busy,done=%b edges=%0d expected 0000 edges=0", {s.arvalid, s.rready, busy, done}, cyc - c_before);
        end
        checks++;
        if (line_data !== 256'h0) begin
            errors++;
            $display("FAIL mid_reset_line: got %h expected 0", line_data);
        end
        @(negedge clk);
        s.rvalid  = 1'b0;
        s.arready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = 32'h70 + 32'(i);
        drive_txn(32'h2000_0004, 1'b0, 0, 1'b0, 8, -1, 32'h70);
        checks++;
        if (obs_araddr !== 32'h2000_0000 || obs_done_cycle !== 10 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_txn: got %h done@%0d err=%b expected 20000000 done@10 err=0", obs_araddr, obs_done_cycle, obs_err);
        end
        checks++;
        if (line_data !== exp_line) begin
            errors++;
            $display("FAIL after_reset_line: got %h expected %h", line_data, exp_line);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cached_line();
        test_stall();
        test_resp_error();
        test_early_rlast();
        test_extra_beat();
        test_uncached();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_refill_reader.md
# axi_refill_reader

AXI4 read-master stage that turns a cache miss request into one AXI read burst and assembles the returned beats into a full cache line. It sits directly upstream of the AXI read arbiter. One instance serves the instruction-cache port and one serves the data-cache port. It drives an arbiter master port (`araddr/arlen/arsize/arburst/arvalid`, `rdata/rresp/rlast/rvalid/rready`) and presents the finished line to the cache.

## Interface
Parameters:
- `LINE_WORDS`, default 8: 32-bit words per cache line; legal values 1, 2, 4, 8, 16.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: miss request; sampled only in IDLE.
- `req_addr` in 32: miss byte address.
- `req_uncached` in 1: 1 = single-word uncached read.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `line_data` is complete.
- `err` out 1: valid with `done`; 1 if any beat had `rresp != OKAY` or the beat count was wrong.
- `line_data` out 32*LINE_WORDS: word k at bits [32k+31:32k].
- `araddr` out 32; `arlen` out 4; `arsize` out 3; `arburst` out 2; `arvalid` out 1; `arready` in 1.
- `rdata` in 32; `rresp` in 2; `rlast` in 1; `rvalid` in 1; `rready` out 1.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - `req` = 1 latches the request and moves to ADDR.
  - Cached request: `araddr` = `req_addr` with the low log2(LINE_WORDS*4) bits cleared, `arlen` = LINE_WORDS-1, `arburst` = INCR (01).
  - Uncached request: `araddr` = `req_addr` with bits [1:0] cleared, `arlen` = 0, `arburst` = INCR.
  - `arsize` = 3'b010 always.
- ADDR:
  - `arvalid` = 1.
  - AR fields stay stable until `arready`.
  - `arvalid & arready` moves to DATA and clears the beat counter.
- DATA:
  - `rready` = 1.
  - Each `rvalid & rready` beat writes `rdata` into word[cnt] and increments `cnt`.
  - Uncached: the beat writes word[`req_addr[log2(LINE_WORDS*4)-1:2]`], so the requested word sits at its natural line slot.
  - `cnt` saturates at LINE_WORDS. Beats arriving when `cnt` = LINE_WORDS are consumed but not stored, and set the error flag.
  - Any `rresp != 00` sets the sticky error flag.
  - A beat with `rlast` moves to DONE. If the beat count differs from `arlen`+1, set the error flag.
- DONE: `done` = 1 and `err` = error flag for exactly one cycle, then IDLE.
- `line_data` holds its value until the next transaction's first beat overwrites a word.
- The error flag clears on request acceptance.
- `req` asserted outside IDLE is ignored; the cache must hold `req` until `busy` is seen.

## Timing
- Reset values: state = IDLE; `busy`, `done`, `err`, `arvalid`, `rready` = 0; AR fields = 0; `line_data` = 0.
- Reset is asynchronous. Reset mid-transaction drops `arvalid`/`rready` immediately; the system reset is global, so there is no AXI drain.
- Minimum latency, cached, arready = 1 and zero-wait slave:
  - cycle 0: `req` accepted.
  - cycle 1: `arvalid` = 1, handshake.
  - cycles 2..2+N-1: beats.
  - cycle 2+N: `done`.
- `rvalid` gaps stall the counter. No beat is lost; `rready` stays high for the whole of DATA.
- `rvalid` seen during ADDR is not accepted (`rready` = 0).
- `done` and a new `req` cannot overlap: a request is accepted at the earliest in the cycle after `done`.
- All outputs are registered except `rready`, which decodes the state register.

## Structure
- Shared package `axi_pkg`:
  - width constants ADDR/DATA/LEN/SIZE/BURST/RESP.
  - `AXI_BURST_INCR`, `AXI_SIZE_4B`, `AXI_RESP_OKAY`.
  - FSM state enum `refill_state_t`.
- The same package also serves the read arbiter.
- No sub-module: the line buffer is a flat register array inside this block.

## Test plan
- Cached, LINE_WORDS = 8, `req_addr` = 0x1000_0024, zero-wait slave returning 0xA0..0xA7 -> `araddr` = 0x1000_0020, `arlen` = 7, `done` at cycle 10, `line_data` words 0..7 = 0xA0..0xA7, `err` = 0.
- Slave holds `arready` low 5 cycles, then inserts one `rvalid` gap per beat -> AR fields stable throughout, correct line, `done` delayed accordingly.
- Uncached, `req_addr` = 0x1FC0_0008, `rdata` = 0xDEAD_BEEF -> `arlen` = 0, `araddr` = 0x1FC0_0008, word 2 = 0xDEAD_BEEF, `done` at cycle 3.
- Beat 4 returns `rresp` = 2'b10 -> burst completes, `err` = 1 with `done`; next request shows `err` = 0.
- Early `rlast` on beat 6 of 8 -> DONE after beat 6, `err` = 1. Extra beat 9 without `rlast` -> consumed, `err` = 1.
- Assert `rst_n` low during DATA, beat 3 -> `arvalid`, `rready`, `busy` go 0 with no clock edge. After release a new request completes normally.
